stream_fetch_engine: RTL and testbench

Parametrised memory-to-core fetch engine. On `start` it walks a strided address sequence, issues read requests on the memory request channel, buffers responses in an internal FIFO, and streams the returned words to `matrix_core` over the valid/ready source channel. The memory response channel has no backpressure, so issue is credit-limited by free FIFO space. Replaces the single-entry skid-buffer fetch path with configurable width, depth, stride and outstanding-request count.

---
 rtl/stream_fetch_engine_if.sv | 40 ++++
 rtl/stream_fetch_engine.sv | 171 +++++++++++++++++
 tb/tb_stream_fetch_engine.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_fetch_engine_if.sv
// Handshake bundle for stream_fetch_engine: memory request/response channels
// and the valid/ready source stream toward matrix_core.
interface stream_fetch_engine_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  m_req_vld;
    logic                  m_req_rdy;
    logic [ADDR_WIDTH-1:0] m_req_addr;
    logic                  m_rsp_vld;
    logic [DATA_WIDTH-1:0] m_rsp_data;
    logic                  src_vld;
    logic                  src_rdy;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_last;

    modport master (
        output m_req_vld,
        output m_req_addr,
        input  m_req_rdy,
        input  m_rsp_vld,
        input  m_rsp_data,
        output src_vld,
        output src_data,
        output src_last,
        input  src_rdy
    );

    modport slave (
        input  m_req_vld,
        input  m_req_addr,
        output m_req_rdy,
        output m_rsp_vld,
        output m_rsp_data,
        input  src_vld,
        input  src_data,
        input  src_last,
        output src_rdy
    );
endinterface

// File: rtl/stream_fetch_engine.sv
// Strided memory-to-core fetch engine: credit-limited read issue, response
// FIFO, and valid/ready stream output with last-word marking.
module stream_fetch_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    stream_fetch_engine_if.master bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  req_cnt_q, req_cnt_d;
    logic [LEN_WIDTH-1:0]  rsp_cnt_q, rsp_cnt_d;
    logic [LEN_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

    logic [CNT_W-1:0] credits;
    logic             req_vld;
    logic             req_hs;
    logic             rsp_push;
    logic             rsp_spurious;
    logic             fifo_vld;
    logic             src_pop;
    logic             src_last;

    // Every buffered word and every outstanding request holds a FIFO slot,
    // so a legitimate response can never find the FIFO full.
    assign credits      = CNT_W'(FIFO_DEPTH) - fifo_cnt_q - outst_q;
    assign req_vld      = (state_q == S_ISSUE) && (credits != '0);
    assign req_hs       = req_vld && bus.m_req_rdy;
    assign rsp_push     = bus.m_rsp_vld && (outst_q != '0);
    assign rsp_spurious = bus.m_rsp_vld && (outst_q == '0);
    assign fifo_vld     = (fifo_cnt_q != '0);
    assign src_pop      = fifo_vld && bus.src_rdy;
    assign src_last     = fifo_vld && (pop_cnt_q == len_q - LEN_ONE);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        len_d     = len_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        pop_cnt_d = pop_cnt_q;
        err_d     = err_q | rsp_spurious;

        if (rsp_push) rsp_cnt_d = rsp_cnt_q - LEN_ONE;
        if (src_pop)  pop_cnt_d = pop_cnt_q + LEN_ONE;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d    = cfg_base;
                    stride_d  = cfg_stride;
                    len_d     = cfg_len;
                    req_cnt_d = cfg_len;
                    rsp_cnt_d = cfg_len;
                    pop_cnt_d = '0;
                    err_d     = rsp_spurious;
                    // Zero length passes through DRAIN so done lands two cycles after start.
                    state_d   = (cfg_len == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_hs) begin
                    addr_d    = addr_q + stride_q;
                    req_cnt_d = req_cnt_q - LEN_ONE;
                    if (req_cnt_q == LEN_ONE) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (((rsp_cnt_q == '0) && (fifo_cnt_q == '0)) || (src_pop && src_last))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        outst_d    = outst_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (req_hs && !rsp_push)      outst_d = outst_q + CNT_ONE;
        else if (!req_hs && rsp_push) outst_d = outst_q - CNT_ONE;

        if (rsp_push && !src_pop)      fifo_cnt_d = fifo_cnt_q + CNT_ONE;
        else if (!rsp_push && src_pop) fifo_cnt_d = fifo_cnt_q - CNT_ONE;

        if (rsp_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (src_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            outst_q    <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            len_q      <= len_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            outst_q    <= outst_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) fifo_mem_q[wr_ptr_q] <= bus.m_rsp_data;
    end

    assign busy           = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    assign bus.m_req_vld  = req_vld;
    assign bus.m_req_addr = addr_q;
    assign bus.src_vld    = fifo_vld;
    // Storage is not reset, so gate the head word to keep the output clean when empty.
    assign bus.src_data   = fifo_vld ? fifo_mem_q[rd_ptr_q] : '0;
    assign bus.src_last   = src_last;

endmodule

// File: tb/tb_stream_fetch_engine.sv
// Directed bench for stream_fetch_engine with a transfer-level reference model
// and a 2-cycle-latency memory that returns addr + 0xA000.
module tb_stream_fetch_engine;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [LW-1:0] cfg_len;
  logic [AW-1:0] cfg_stride;
  logic          busy, done, err;

  stream_fetch_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  stream_fetch_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_stride(cfg_stride), .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transfer-level model: addresses are base + i*stride, data is that address + 0xA000.
  bit            model_on = 1'b0;
  int            m_len, req_idx, pop_idx, start_cyc, done_due, done_cnt;
  logic [AW-1:0] m_base, m_stride;
  logic [AW-1:0] req_log[$];
  logic [DW-1:0] data_log[$];
  bit            last_log[$];

  function automatic logic [AW-1:0] exp_addr(input int i);
    return m_base + AW'(i) * m_stride;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int i);
    return DW'(32'hA000) + DW'(exp_addr(i));
  endfunction

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t pend_q[$];
  bit   spur = 1'b0;

  always @(negedge clk) begin
    rsp_t r;
    if (!rst && bus.m_req_vld && bus.m_req_rdy) begin
      r.due  = cyc + 2;
      r.data = DW'(32'hA000) + DW'(bus.m_req_addr);
      pend_q.push_back(r);
    end
  end

  initial begin
    bus.m_rsp_vld  = 1'b0;
    bus.m_rsp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (spur) begin
        bus.m_rsp_vld  = 1'b1;
        bus.m_rsp_data = 32'hDEAD_BEEF;
        spur = 1'b0;
      end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        bus.m_rsp_vld  = 1'b1;
        bus.m_rsp_data = pend_q[0].data;
        void'(pend_q.pop_front());
      end else begin
        bus.m_rsp_vld  = 1'b0;
      end
    end
  end

  bit            prev_req_stall = 1'b0, prev_src_stall = 1'b0;
  logic [AW-1:0] prev_req_addr;
  logic [DW-1:0] prev_src_data;
  logic          prev_src_last;

  always @(negedge clk) begin
    if (rst || !model_on) begin
      prev_req_stall = 1'b0;
      prev_src_stall = 1'b0;
    end else begin
      if (prev_req_stall) begin
        chk1("req_vld_hold", bus.m_req_vld, 1'b1);
        chkv("req_addr_hold", 32'(bus.m_req_addr), 32'(prev_req_addr));
      end
      if (prev_src_stall) begin
        chk1("src_vld_hold", bus.src_vld, 1'b1);
        chkv("src_data_hold", bus.src_data, prev_src_data);
        chk1("src_last_hold", bus.src_last, prev_src_last);
      end
      if (bus.m_req_vld) begin
        chk1("req_allowed", req_idx < m_len, 1'b1);
        if (bus.m_req_rdy) begin
          chkv("req_addr", 32'(bus.m_req_addr), 32'(exp_addr(req_idx)));
          req_log.push_back(bus.m_req_addr);
          req_idx++;
          chk1("in_flight_bound", (req_idx - pop_idx) <= DEPTH, 1'b1);
        end
      end
      if (bus.src_vld && bus.src_rdy) begin
        chk1("src_extra", pop_idx < m_len, 1'b1);
        chkv("src_data", bus.src_data, exp_data(pop_idx));
        chk1("src_last", bus.src_last, pop_idx == m_len - 1);
        data_log.push_back(bus.src_data);
        last_log.push_back(bus.src_last);
        if (pop_idx == m_len - 1) done_due = cyc + 1;
        pop_idx++;
      end
      chk1("done", done, cyc == done_due);
      chk1("busy", busy, (cyc > start_cyc) && (done_due < 0 || cyc < done_due));
      if (done) done_cnt++;
      prev_req_stall = bus.m_req_vld && !bus.m_req_rdy;
      prev_req_addr  = bus.m_req_addr;
      prev_src_stall = bus.src_vld && !bus.src_rdy;
      prev_src_data  = bus.src_data;
      prev_src_last  = bus.src_last;
    end
  end

  task automatic do_start(input logic [AW-1:0] base, input int len, input logic [AW-1:0] stride);
    @(posedge clk);
    #1;
    cfg_base   = base;
    cfg_len    = LW'(len);
    cfg_stride = stride;
    start      = 1'b1;
    m_base     = base;
    m_len      = len;
    m_stride   = stride;
    req_idx    = 0;
    pop_idx    = 0;
    start_cyc  = cyc;
    done_due   = (len == 0) ? cyc + 2 : -1;
    req_log.delete();
    data_log.delete();
    last_log.delete();
    model_on   = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk1(name, n < limit, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_req_vld"}, bus.m_req_vld, 1'b0);
    chkv({tag, "_req_addr"}, 32'(bus.m_req_addr), 32'h0);
    chk1({tag, "_src_vld"}, bus.src_vld, 1'b0);
    chk1({tag, "_src_last"}, bus.src_last, 1'b0);
    chkv({tag, "_src_data"}, bus.src_data, 32'h0);
  endtask

  logic [AW-1:0] basic_addr [4] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
  logic [DW-1:0] basic_data [4] = '{32'hA100, 32'hA101, 32'hA102, 32'hA103};
  bit            basic_last [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [AW-1:0] wrap_addr  [3] = '{16'hFFFE, 16'h0001, 16'h0004};
  logic [DW-1:0] rst_data   [2] = '{32'hA600, 32'hA601};

  initial begin
    int d0, n;
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_stride = '0;
    bus.m_req_rdy = 1'b0; bus.src_rdy = 1'b0;
    done_cnt = 0; done_due = -1; start_cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0; bus.m_req_rdy = 1'b1; bus.src_rdy = 1'b1;

    // Basic transfer
    d0 = done_cnt;
    do_start(16'h0100, 4, 16'd1);
    @(negedge clk);
    chk1("first_req_vld", bus.m_req_vld, 1'b1);
    chkv("first_req_addr", 32'(bus.m_req_addr), 32'h0100);
    wait_done("basic_done_timeout", 100);
    repeat (3) @(negedge clk);
    chkv("basic_done_pulses", done_cnt - d0, 1);
    chkv("basic_n_words", data_log.size(), 4);
    for (int i = 0; i < 4 && i < data_log.size() && i < req_log.size(); i++) begin
      chkv("basic_addr_lit", 32'(req_log[i]), 32'(basic_addr[i]));
      chkv("basic_data_lit", data_log[i], basic_data[i]);
      chk1("basic_last_lit", last_log[i], basic_last[i]);
    end

    // Backpressure: credits cap issue at FIFO_DEPTH
    bus.src_rdy = 1'b0;
    do_start(16'h0200, 20, 16'd1);
    repeat (30) @(negedge clk);
    chkv("bp_req_issued", req_idx, 8);
    chk1("bp_req_vld_low", bus.m_req_vld, 1'b0);
    chk1("bp_src_vld", bus.src_vld, 1'b1);
    chkv("bp_head_data", bus.src_data, 32'hA200);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      bus.src_rdy = i[0];
    end
    @(posedge clk);
    #1;
    bus.src_rdy = 1'b1;
    wait_done("bp_done_timeout", 200);
    chkv("bp_words", pop_idx, 20);

    // Stride with address wrap
    do_start(16'hFFFE, 3, 16'd3);
    wait_done("wrap_done_timeout", 100);
    chkv("wrap_n_req", req_log.size(), 3);
    for (int i = 0; i < 3 && i < req_log.size(); i++)
      chkv("wrap_addr_lit", 32'(req_log[i]), 32'(wrap_addr[i]));

    // Zero length
    do_start(16'h0000, 0, 16'd1);
    wait_done("zero_done_timeout", 20);
    chkv("zero_done_latency", cyc - start_cyc, 2);
    chkv("zero_no_req", req_idx, 0);

    // Start while busy is ignored; request stalls exercise address hold
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    do_start(16'h0300, 10, 16'd2);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bus.m_req_rdy = i[0];
      if (i == 3) begin
        start = 1'b1; cfg_base = 16'h0700; cfg_len = 16'd3; cfg_stride = 16'd1;
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0; bus.m_req_rdy = 1'b1;
    wait_done("busy_start_done_timeout", 200);
    repeat (3) @(negedge clk);
    chkv("busy_start_words", pop_idx, 10);
    chkv("busy_start_reqs", req_idx, 10);
    chkv("busy_start_done_pulses", done_cnt - d0, 1);

    // Spurious response in IDLE
    @(negedge clk);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    chk1("spur_err", err, 1'b1);
    chk1("spur_no_src_vld", bus.src_vld, 1'b0);
    do_start(16'h0400, 1, 16'd1);
    @(negedge clk);
    chk1("start_clears_err", err, 1'b0);
    wait_done("err_done_timeout", 50);

    // Reset mid-transfer after three words
    do_start(16'h0500, 8, 16'd1);
    n = 0;
    while (pop_idx < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("rst_reach_three", n < 100, 1'b1);
    @(posedge clk);
    #1;
    model_on = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    chk1("rst_inflight_err", err, 1'b1);
    repeat (10) @(negedge clk);
    do_start(16'h0600, 2, 16'd1);
    @(negedge clk);
    chk1("rst_restart_err_clr", err, 1'b0);
    wait_done("rst_restart_done_timeout", 50);
    chkv("rst_restart_words", data_log.size(), 2);
    for (int i = 0; i < 2 && i < data_log.size(); i++)
      chkv("rst_restart_data_lit", data_log[i], rst_data[i]);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
    $fatal(1);
  end
endmodule
